// File: rtl/taiko_pkg.sv
// Shared definitions for the note scheduler: FSM encoding, note and result
// codes, and a saturating 8-bit add used by every tally.
package taiko_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LATCH,
    WAIT_BEAT,
    DRAIN,
    DONE
  } sched_state_t;

  localparam logic [2:0] NOTE_REST = 3'd0;
  localparam logic [2:0] NOTE_END  = 3'd7;

  localparam logic [1:0] RES_GREAT = 2'b01;
  localparam logic [1:0] RES_GOOD  = 2'b10;

  // Codes 1-4 are playable notes; 0, 5 and 6 behave as rests.
  function automatic logic is_note(input logic [2:0] code);
    return (code >= 3'd1) && (code <= 3'd4);
  endfunction

  function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[8] ? 8'hFF : s[7:0];
  endfunction

endpackage

// File: rtl/note_scheduler_result_tally.sv
// Per-cycle popcount of slot results with saturating great/good/miss tallies
// and a consecutive-hit combo counter.
module result_tally
  import taiko_pkg::*;
#(
  parameter int NUM_SLOTS = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clear,
  input  logic                   enable,
  input  logic [NUM_SLOTS-1:0]   done,
  input  logic [2*NUM_SLOTS-1:0] result,
  input  logic                   drop,
  output logic [7:0]             great_count,
  output logic [7:0]             good_count,
  output logic [7:0]             miss_count,
  output logic [7:0]             combo
);

  logic [7:0] great_inc;
  logic [7:0] good_inc;
  logic [7:0] miss_inc;

  // Count this cycle's results per category; a dropped note counts as a miss.
  always_comb begin
    great_inc = '0;
    good_inc  = '0;
    miss_inc  = '0;
    for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
      if (done[i]) begin
        if (result[2*i +: 2] == RES_GREAT)
          great_inc = great_inc + 8'd1;
        else if (result[2*i +: 2] == RES_GOOD)
          good_inc = good_inc + 8'd1;
        else
          miss_inc = miss_inc + 8'd1;
      end
    end
    if (drop)
      miss_inc = miss_inc + 8'd1;
  end

  // Apply the whole cycle's sums at once; any miss zeroes combo.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      great_count <= '0;
      good_count  <= '0;
      miss_count  <= '0;
      combo       <= '0;
    end else if (enable) begin
      great_count <= sat_add8(great_count, great_inc);
      good_count  <= sat_add8(good_count, good_inc);
      miss_count  <= sat_add8(miss_count, miss_inc);
      combo       <= (miss_inc != '0) ? '0 : sat_add8(combo, great_inc + good_inc);
    end
  end

endmodule

// File: rtl/note_scheduler.sv
// Walks a note chart one beat at a time, launches notes into the lowest free
// slot and tallies slot results.
module note_scheduler
  import taiko_pkg::*;
#(
  parameter int NUM_SLOTS = 4,
  parameter int ADDR_W    = 8
) (
  input  logic                   CLOCK_50,
  input  logic                   Reset,
  input  logic                   started,
  input  logic                   beatTick,
  output logic [ADDR_W-1:0]      chartAddr,
  input  logic [2:0]             chartData,
  output logic [NUM_SLOTS-1:0]   slotStart,
  output logic [2:0]             slotCode,
  input  logic [NUM_SLOTS-1:0]   slotBusy,
  input  logic [NUM_SLOTS-1:0]   slotDone,
  input  logic [2*NUM_SLOTS-1:0] slotResult,
  output logic [7:0]             greatCount,
  output logic [7:0]             goodCount,
  output logic [7:0]             missCount,
  output logic [7:0]             combo,
  output logic                   chartDone,
  output logic                   overflowErr
);

  sched_state_t         state;
  logic [2:0]           noteReg;
  logic [NUM_SLOTS-1:0] free_sel;
  logic                 any_free;
  logic                 dispatch;
  logic                 drop;

  // Pick the lowest-index slot that is not busy (busy wins over done).
  always_comb begin
    free_sel = '0;
    any_free = 1'b0;
    for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
      if (!slotBusy[i] && !any_free) begin
        free_sel[i] = 1'b1;
        any_free    = 1'b1;
      end
    end
  end

  // A dispatch beat with no free slot turns into a dropped note.
  always_comb begin
    dispatch = (state == WAIT_BEAT) && started && beatTick && is_note(noteReg);
    drop     = dispatch && !any_free;
  end

  // Scheduler FSM with registered outputs.
  always_ff @(posedge CLOCK_50) begin
    if (Reset) begin
      state       <= IDLE;
      chartAddr   <= '0;
      noteReg     <= NOTE_REST;
      slotStart   <= '0;
      slotCode    <= '0;
      chartDone   <= 1'b0;
      overflowErr <= 1'b0;
    end else begin
      slotStart <= '0;
      slotCode  <= '0;
      case (state)
        IDLE: begin
          chartAddr <= '0;
          chartDone <= 1'b0;
          if (started) begin
            overflowErr <= 1'b0;
            state       <= FETCH;
          end
        end
        FETCH: begin
          if (!started) begin
            chartAddr <= '0;
            state     <= IDLE;
          end else begin
            state <= LATCH;
          end
        end
        LATCH: begin
          if (!started) begin
            chartAddr <= '0;
            state     <= IDLE;
          end else begin
            noteReg <= chartData;
            state   <= WAIT_BEAT;
          end
        end
        WAIT_BEAT: begin
          if (!started) begin
            chartAddr <= '0;
            state     <= IDLE;
          end else if (beatTick) begin
            if (noteReg == NOTE_END) begin
              state <= DRAIN;
            end else begin
              if (dispatch) begin
                if (any_free) begin
                  slotStart <= free_sel;
                  slotCode  <= noteReg;
                end else begin
                  overflowErr <= 1'b1;
                end
              end
              // The last address ends the chart rather than wrapping to 0.
              if (chartAddr == '1) begin
                state <= DRAIN;
              end else begin
                chartAddr <= chartAddr + ADDR_W'(1);
                state     <= FETCH;
              end
            end
          end
        end
        DRAIN: begin
          if (!started) begin
            chartAddr <= '0;
            state     <= IDLE;
          end else if (slotBusy == '0) begin
            chartDone <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (!started) begin
            chartDone <= 1'b0;
            chartAddr <= '0;
            state     <= IDLE;
          end else begin
            chartDone <= 1'b1;
          end
        end
        default: begin
          chartAddr <= '0;
          chartDone <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

  result_tally #(
    .NUM_SLOTS(NUM_SLOTS)
  ) u_tally (
    .clk        (CLOCK_50),
    .reset      (Reset),
    .clear      ((state == IDLE) && started),
    .enable     (state != IDLE),
    .done       (slotDone),
    .result     (slotResult),
    .drop       (drop),
    .great_count(greatCount),
    .good_count (goodCount),
    .miss_count (missCount),
    .combo      (combo)
  );

endmodule

// File: doc/note_scheduler.md
NOTE_SCHEDULER -- requirements
Module: note_scheduler

Interface
REQ-001 Parameter NUM_SLOTS, default 4, number of note-slot datapaths scheduled.
REQ-002 Parameter ADDR_W, default 8, chart ROM address width.
REQ-003 CLOCK_50  in  1  sole clock; all state changes on its rising edge.
REQ-004 Reset  in  1  synchronous, active-high reset.
REQ-005 started  in  1  level; 1 = song running, 0 = abort/idle.
REQ-006 beatTick  in  1  one-cycle pulse per beat.
REQ-007 chartAddr  out  ADDR_W  chart ROM address.
REQ-008 chartData  in  3  note code, valid one cycle after chartAddr; 0 = rest, 1-4 = note types, 7 = end marker, 5-6 = treated as rest.
REQ-009 slotStart  out  NUM_SLOTS  one-hot one-cycle launch pulse to a slot.
REQ-010 slotCode  out  3  note code for the launched slot, valid with slotStart.
REQ-011 slotBusy  in  NUM_SLOTS  slot i holds a live note.
REQ-012 slotDone  in  NUM_SLOTS  slot i finished this cycle.
REQ-013 slotResult  in  2*NUM_SLOTS  slot i result in bits [2i+1:2i]: 01 great, 10 good, 00/11 miss; valid with slotDone[i].
REQ-014 greatCount, goodCount, missCount  out  8 each  saturating tallies.
REQ-015 combo  out  8  saturating consecutive-hit count.
REQ-016 chartDone  out  1  chart finished and all slots drained.
REQ-017 overflowErr  out  1  sticky; a note was dropped because no slot was free.

Function
REQ-018 FSM states SHALL be IDLE, FETCH, LATCH, WAIT_BEAT, DRAIN, DONE.
REQ-019 IDLE: chartAddr=0; on started=1 go to FETCH and clear all tallies, combo and overflowErr.
REQ-020 FETCH: drive chartAddr for one cycle, then go to LATCH.
REQ-021 LATCH: register chartData into noteReg, then go to WAIT_BEAT.
REQ-022 WAIT_BEAT without beatTick: hold.
REQ-023 WAIT_BEAT with beatTick and noteReg=7: go to DRAIN; chartAddr is not incremented.
REQ-024 WAIT_BEAT with beatTick and noteReg a rest code: increment chartAddr, go to FETCH.
REQ-025 WAIT_BEAT with beatTick and noteReg in 1-4: pulse slotStart on the lowest-index slot with slotBusy=0, drive slotCode=noteReg, increment chartAddr, go to FETCH.
REQ-026 If no slot is free at dispatch, the note SHALL be dropped: missCount+1, combo=0, overflowErr=1; then increment chartAddr and go to FETCH.
REQ-027 An increment of chartAddr from all-ones SHALL go to DRAIN instead of wrapping.
REQ-028 DRAIN: when slotBusy is all-zero, go to DONE.
REQ-029 DONE: chartDone=1; when started=0, go to IDLE.
REQ-030 started=0 in FETCH, LATCH, WAIT_BEAT or DRAIN: go to IDLE next cycle, issue no slotStart, retain tallies.
REQ-031 Results: every slotDone bit asserted in a cycle SHALL be tallied in that cycle, outside IDLE only; the per-cycle sum is applied at once.
REQ-032 Any counter reaching 255 SHALL hold at 255.
REQ-033 combo SHALL add the number of hits (great+good) that cycle.
REQ-034 Any miss in a cycle, including a drop, SHALL force combo=0 regardless of simultaneous hits.
REQ-035 slotStart SHALL be zero in every cycle except a dispatch cycle.
REQ-036 A slot with slotDone=1 and slotBusy=1 in the same cycle SHALL be treated as busy.

Reset
REQ-037 Reset=1 SHALL, at the next edge: enter IDLE; set chartAddr=0, slotStart=0, slotCode=0, all counts=0, combo=0, chartDone=0, overflowErr=0. Reset has priority over all other inputs, including mid-chart.

Structure
REQ-038 Shared package taiko_pkg SHALL hold: FSM state encoding; note codes (REST=0, END=7); result codes (GREAT=2'b01, GOOD=2'b10).
REQ-039 The block SHALL contain one sub-module, result_tally: a per-cycle popcount of great/good/miss across slots with 8-bit saturating accumulation and combo logic.

Verification
REQ-040 Chart {1,0,2,7}, all slots idle, started=1, beatTick every 10 cycles -> slotStart=0001 with code 1 on beat 1; no start on beat 2; slotStart=0001 with code 2 on beat 3; DRAIN on beat 4; chartDone=1 once slotBusy=0.
REQ-041 slotBusy=0011 at dispatch -> slotStart=0100.
REQ-042 slotBusy=1111 at dispatch -> no start; missCount=1, overflowErr=1, combo=0.
REQ-043 combo=5, then slotDone=0011 with results great+miss in one cycle -> greatCount+1, missCount+1, combo=0.
REQ-044 greatCount=254, then two greats in one cycle -> greatCount=255, and it stays at 255 afterwards.
REQ-045 Reset pulse in WAIT_BEAT with nonzero tallies -> next cycle IDLE and all outputs zero; started=0 mid-chart -> IDLE, no further slotStart.
